cascade_counter: RTL and testbench

Parametrised, cascadable modulo-N up/down counter: the registered successor to the 4-bit combinational incrementer. It holds a WIDTH-bit count, steps it by one on qualified clock edges, and wraps at a programmable modulus. A lookahead carry/borrow output lets several instances chain into wide synchronous counters. Used as the timebase and event counter in the lab datapaths.

---
 rtl/cascade_counter.sv | 60 ++++++
 tb/tb_cascade_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// rtl/cascade_counter.sv - cascadable modulo-N up/down counter with lookahead carry/borrow
// Define CASCADE_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module cascade_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             carry_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  logic             step;
  logic             terminal;
  logic [WIDTH-1:0] load_clamped;

  assign step         = en & carry_in;
  assign terminal     = up ? (count == MAX_COUNT) : (count == '0);
  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_COUNT;

`ifdef CASCADE_COUNTER_SATURATE_EN
  assign carry_out = 1'b0;
`else
  assign carry_out = step & terminal & ~reset & ~load;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= load_clamped;
      wrapped <= 1'b0;
    end else if (step && terminal) begin
`ifdef CASCADE_COUNTER_SATURATE_EN
      count   <= count;
      wrapped <= 1'b0;
`else
      count   <= up ? '0 : MAX_COUNT;
      wrapped <= 1'b1;
`endif
    end else if (step) begin
      count   <= up ? count + 1'b1 : count - 1'b1;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cascade_counter.sv
// tb/tb_cascade_counter.sv - randomized two-stage cascade bench against an arithmetic model
// Honours CASCADE_COUNTER_SATURATE_EN in the model when the design is built that way.
module tb_cascade_counter;

  localparam int W = 4;
  localparam int M = 10;
`ifdef CASCADE_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, en, up, carry_in, load;
  logic [W-1:0] load_val;
  logic [W-1:0] lo_count, hi_count;
  logic         lo_carry, hi_carry, lo_wrapped, hi_wrapped;

  int n_checks = 0;
  int n_pass   = 0;

  int m_lo = 0, m_hi = 0;
  bit m_lo_wr = 1'b0, m_hi_wr = 1'b0;

  always #5 clk = ~clk;

  cascade_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
    .clk(clk), .reset(reset), .en(en), .up(up), .carry_in(carry_in),
    .load(load), .load_val(load_val),
    .count(lo_count), .carry_out(lo_carry), .wrapped(lo_wrapped)
  );

  cascade_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
    .clk(clk), .reset(reset), .en(en), .up(up), .carry_in(lo_carry),
    .load(load), .load_val(load_val),
    .count(hi_count), .carry_out(hi_carry), .wrapped(hi_wrapped)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Would a step from cnt leave the 0..M-1 range?
  function automatic bit leaves_range(input int cnt, input bit dir_up);
    int raw;
    raw = dir_up ? cnt + 1 : cnt - 1;
    return (raw < 0) || (raw >= M);
  endfunction

  function automatic bit model_carry(input int cnt, input bit stp);
    return stp && leaves_range(cnt, up) && !reset && !load && !SAT;
  endfunction

  task automatic model_edge(inout int cnt, output bit wr, input bit stp);
    wr = 1'b0;
    if (reset) cnt = 0;
    else if (load) cnt = (int'(load_val) < M) ? int'(load_val) : M - 1;
    else if (stp) begin
      if (leaves_range(cnt, up)) begin
        if (!SAT) begin
          cnt = (cnt + (up ? 1 : M - 1)) % M;
          wr  = 1'b1;
        end
      end else begin
        cnt = cnt + (up ? 1 : -1);
      end
    end
  endtask

  task automatic tick();
    bit lo_step, hi_step, exp_lo_co, exp_hi_co;
    @(negedge clk);
    lo_step   = en & carry_in;
    exp_lo_co = model_carry(m_lo, lo_step);
    hi_step   = en & exp_lo_co;
    exp_hi_co = model_carry(m_hi, hi_step);
    check("lo_carry_out", int'(lo_carry), int'(exp_lo_co));
    check("hi_carry_out", int'(hi_carry), int'(exp_hi_co));
    model_edge(m_lo, m_lo_wr, lo_step);
    model_edge(m_hi, m_hi_wr, hi_step);
    @(posedge clk);
    #1;
    check("lo_count", int'(lo_count), m_lo);
    check("hi_count", int'(hi_count), m_hi);
    check("lo_wrapped", int'(lo_wrapped), int'(m_lo_wr));
    check("hi_wrapped", int'(hi_wrapped), int'(m_hi_wr));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; carry_in = 1'b1; load = 1'b0; load_val = '0;
    tick();

    // Reset wins over a simultaneous load and enable.
    en = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    check("reset_count", int'(lo_count), 0);
    check("reset_wrapped", int'(lo_wrapped), 0);

    // Up through the modulus.
    reset = 1'b0; load = 1'b0; up = 1'b1; carry_in = 1'b1;
    repeat (10) tick();
`ifdef CASCADE_COUNTER_SATURATE_EN
    check("up_sat_lo", int'(lo_count), 9);
    check("up_sat_hi", int'(hi_count), 0);
`else
    check("up_wrap_lo", int'(lo_count), 0);
    check("up_wrap_hi", int'(hi_count), 1);
`endif

    // Load 2 then count down past zero.
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0; up = 1'b0;
    repeat (3) tick();

    // Clamped load with a competing step, then step up.
    load = 1'b1; load_val = 4'd13; up = 1'b1;
    tick();
    check("clamp_count", int'(lo_count), 9);
    load = 1'b0;
    tick();

    // Two-stage cascade from reset for 25 edges.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (25) tick();
`ifdef CASCADE_COUNTER_SATURATE_EN
    check("cascade_hi", int'(hi_count), 0);
    check("cascade_lo", int'(lo_count), 9);
    up = 1'b0;
    repeat (12) tick();
    check("down_sat_lo", int'(lo_count), 0);
`else
    check("cascade_hi", int'(hi_count), 2);
    check("cascade_lo", int'(lo_count), 5);
`endif

    // Randomized traffic.
    repeat (400) begin
      reset    = ($urandom % 25) == 0;
      load     = ($urandom % 12) == 0;
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom % 4) != 0;
      carry_in = ($urandom % 5) != 0;
      up       = ($urandom % 3) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
